// File: rtl/octal_pkg.sv
// Shared definitions for the octal-digit encode/decode pair: digit width, digit-count helpers,
// FSM states and sign encoding.
package octal_pkg;

  localparam int unsigned DIG_W = 3;

  localparam logic SIGN_NEG = 1'b0;
  localparam logic SIGN_POS = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  // Number of octal groups needed to cover a w-bit word.
  function automatic int unsigned nd_of(input int unsigned w);
    return (w + DIG_W - 1) / DIG_W;
  endfunction

  // Valid bits carried by the most-significant group.
  function automatic int unsigned fw_of(input int unsigned w);
    return w - DIG_W * (nd_of(w) - 1);
  endfunction

endpackage

// File: rtl/sign_apply.sv
// Conditional two's-complement negation of a magnitude; shared by the encode and decode sides.
module sign_apply
  import octal_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] mag,
  input  logic         sign,
  output logic [W-1:0] res
);

  assign res = (sign == SIGN_POS) ? mag : (~mag + {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/octal_to_bin.sv
// Rebuilds a signed W-bit word from a sign flag and MSB-first octal digits (valid/ready in and out).
// Define OCT2BIN_OVF_EN to build the first-digit and positive-range overflow detection.
module octal_to_bin
  import octal_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sign_in,
  input  logic         digit_valid,
  input  logic [2:0]   digit,
  output logic         digit_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         overflow
);

  localparam int unsigned ND    = nd_of(W);
  localparam int unsigned FW    = fw_of(W);
  localparam int unsigned IDX_W = $clog2(ND + 1);

  localparam logic [DIG_W-1:0] FW_MASK = DIG_W'((1 << FW) - 1);

  state_t           state_q;
  logic [W-1:0]     acc_q;
  logic [IDX_W-1:0] idx_q;
  logic             sign_q;
  logic             ovf_q;
  logic [W-1:0]     data_q;

  logic             first;
  logic             last;
  logic             restart;
  logic [DIG_W-1:0] digit_eff;
  logic [W-1:0]     acc_next;
  logic [W-1:0]     signed_word;
  logic             first_ovf;
  logic             pos_ovf;

  assign first     = (idx_q == '0);
  assign last      = (idx_q == IDX_W'(ND - 1));
  assign digit_eff = first ? (digit & FW_MASK) : digit;
  // Bits shifted past the top are only the masked-off first-digit bits.
  assign acc_next  = W'({acc_q, digit_eff});

  // Start is honoured in IDLE and LOAD, and in DONE only alongside the output handshake.
  assign restart = start && ((state_q == IDLE) || (state_q == LOAD) ||
                             ((state_q == DONE) && out_ready));

`ifdef OCT2BIN_OVF_EN
  assign first_ovf = first && |(digit & ~FW_MASK);
  assign pos_ovf   = last && (sign_q == SIGN_POS) && acc_next[W-1];
`else
  assign first_ovf = 1'b0;
  assign pos_ovf   = 1'b0;
`endif

  sign_apply #(
    .W (W)
  ) u_sign_apply (
    .mag  (acc_next),
    .sign (sign_q),
    .res  (signed_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      sign_q  <= SIGN_NEG;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else if (restart) begin
      state_q <= LOAD;
      sign_q  <= sign_in;
      acc_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          if (digit_valid) begin
            acc_q <= acc_next;
            idx_q <= idx_q + 1'b1;
            if (first_ovf || pos_ovf) ovf_q <= 1'b1;
            if (last) begin
              data_q  <= signed_word;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digit_ready = (state_q == LOAD);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign overflow    = ovf_q;
  assign out_data    = data_q;

endmodule
